nibble_serial_adder: RTL and testbench
======================================

# nibble_serial_adder

Multi-cycle WIDTH-bit adder that processes one 4-bit nibble per clock through a combinational 4-bit ripple-carry slice, registering the carry between nibbles. It sits directly around the 4-bit adder stage. It feeds the slice's X, Y and carryin each cycle, consumes its S and carryout, and assembles the full-width sum. It trades latency for area wherever wide additions are needed in the datapath.

## Interface
Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 and ≥ 4. NIB = WIDTH/4.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- x  in  WIDTH  operand X; captured on the accepted start edge.
- y  in  WIDTH  operand Y; captured on the accepted start edge.
- cin  in  1  carry-in to nibble 0; captured with x/y.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse; sum/cout valid.
- sum  out  WIDTH  registered result; holds until the next completion.
- cout  out  1  carry out of the MSB nibble; holds like sum.
- ovf  out  1  signed overflow. Present only with NSA_OVF_EN.

## Operation
States:
- IDLE
  - start=1: capture x, y into shift registers; carry_r ← cin; cnt ← 0; go to RUN.
  - start=0: stay in IDLE.
- RUN
  - Each edge: the slice adds x_sh[3:0] + y_sh[3:0] + carry_r.
  - Shift x_sh and y_sh right by 4. Shift S into the top nibble of acc (acc shifts right by 4).
  - carry_r ← carryout; cnt++.
  - When cnt == NIB−1: sum ← {S, acc[WIDTH−1:4]}; cout ← carryout; go to DONE.
- DONE: done=1 for exactly this cycle; unconditionally go to IDLE.

Rules:
- Arithmetic is unsigned modulo 2^WIDTH. {cout,sum} = x + y + cin, exact.
- start while busy (RUN or DONE) is ignored. Captured operands are unaffected by input changes after capture.
- sum/cout never show partial results: they change only on the final RUN edge.
- Carry must ripple across nibble boundaries through carry_r (e.g. 0xFFFF+1).
- rst in any state (including mid-RUN): state ← IDLE; busy, done, sum, cout, ovf, carry_r, cnt ← 0; the in-flight operation is discarded.
- rst and start in the same cycle: rst wins; start is not accepted.

## Timing
- Start accepted at edge E0. Nibble k is processed at edge E(k+1).
- done is high in the cycle after edge E(NIB). For WIDTH=16, done rises 4 cycles after the start edge.
- Earliest back-to-back accept: the edge at the end of the DONE cycle is still not an accept. Next accept is at E(NIB+2) (start held high from IDLE). Throughput: one add per NIB+2 cycles.
- busy rises the cycle after E0 and falls the cycle after done.
- Reset values: all outputs 0.

## Configuration
- NSA_OVF_EN defined:
  - Register the operand sign bits at capture.
  - ovf ← (xs == ys) && (final sum[WIDTH−1] ≠ xs), updated with sum; holds like sum.
- NSA_OVF_EN undefined: ovf port and its logic are absent. All other behaviour is identical.

## Structure
- Shared include header nsa_defs.vh holds:
  - state encodings NSA_IDLE=2'd0, NSA_RUN=2'd1, NSA_DONE=2'd2;
  - the nibble width constant (4);
  - the counter-width derivation for NIB.
- One sub-module: nibble_adder, a combinational 4-bit slice with ports carryin, X[3:0], Y[3:0], S[3:0], carryout. It is instantiated once.

## Test plan
All scenarios use WIDTH=16.
1. x=0x0000, y=0x0000, cin=0 → sum=0x0000, cout=0; done is a single-cycle pulse exactly 4 cycles after the start edge; busy high for 5 cycles.
2. x=0xFFFF, y=0x0001, cin=0 → sum=0x0000, cout=1 (carry crosses all 3 nibble boundaries).
3. x=0xFFFF, y=0xFFFF, cin=1 → sum=0xFFFF, cout=1. Then x=0x5A5A, y=0xA5A5, cin=0 → sum=0xFFFF, cout=0.
4. x=0x7FFF, y=0x0001, cin=0 → sum=0x8000, cout=0, ovf=1 (with NSA_OVF_EN). Then x=0x8000, y=0x8000 → sum=0x0000, cout=1, ovf=1.
5. Start x=0x1234, y=0x1111. Assert start again with x=0xFFFF one cycle later and in the DONE cycle → both ignored; result sum=0x2345; the next accept occurs only after returning to IDLE.
6. Start x=0xFFFF, y=0xFFFF; assert rst 2 cycles later → next cycle: busy=0, done=0, sum=0, cout=0. A new start with x=0x0003, y=0x0004 → sum=0x0007, and no done pulse ever occurs for the aborted operation.

Source files
------------

// File: rtl/nibble_serial_adder_pkg.sv
// nibble_serial_adder_pkg: state type, nibble width and counter sizing for the serial adder.
package nibble_serial_adder_pkg;
`include "nsa_defs.vh"
    typedef enum logic [1:0] {IDLE = `NSA_IDLE, RUN = `NSA_RUN, DONE = `NSA_DONE} state_t;
    localparam int NIB_W = `NSA_NIB_W;
    function automatic int cnt_w(input int nib);
        return `NSA_CNT_W(nib);
    endfunction
endpackage

// File: rtl/nibble_adder.sv
// nibble_adder: combinational 4-bit ripple-carry slice.
module nibble_adder
    import nibble_serial_adder_pkg::*;
(
    input  logic             carryin,
    input  logic [NIB_W-1:0] X,
    input  logic [NIB_W-1:0] Y,
    output logic [NIB_W-1:0] S,
    output logic             carryout
);
    logic [NIB_W:0] w_c;
    assign w_c[0] = carryin;
    for (genvar i = 0; i < NIB_W; i++) begin : g_bit
        assign S[i] = X[i] ^ Y[i] ^ w_c[i];
        assign w_c[i+1] = (X[i] & Y[i]) | (w_c[i] & (X[i] ^ Y[i]));
    end
    assign carryout = w_c[NIB_W];
endmodule

// File: rtl/nsa_defs.vh
// nsa_defs: shared state encodings, nibble width and counter-width helper for nibble_serial_adder.
`ifndef NSA_DEFS_VH
`define NSA_DEFS_VH
`define NSA_IDLE 2'd0
`define NSA_RUN 2'd1
`define NSA_DONE 2'd2
`define NSA_NIB_W 4
`define NSA_CNT_W(n) (((n) > 1) ? $clog2(n) : 1)
`endif

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit adder processing one nibble per clock through a shared slice.
// Optional signed-overflow output enabled by defining NSA_OVF_EN.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef NSA_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);
    localparam int NIB = WIDTH / NIB_W;
    localparam int CW = cnt_w(NIB);
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_x, r_y, r_acc;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [NIB_W-1:0] w_s;
    logic             w_co;
    logic [WIDTH-1:0] w_acc;
`ifdef NSA_OVF_EN
    logic             r_xs, r_ys;
`endif

    nibble_adder u_add (
        .carryin (r_carry),
        .X       (r_x[NIB_W-1:0]),
        .Y       (r_y[NIB_W-1:0]),
        .S       (w_s),
        .carryout(w_co)
    );

    // New nibble enters at the top; after NIB steps nibble 0 has reached bit 0.
    assign w_acc = WIDTH'({w_s, r_acc} >> NIB_W);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_acc   <= '0;
`ifdef NSA_OVF_EN
            ovf     <= 1'b0;
            r_xs    <= 1'b0;
            r_ys    <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_x     <= x;
                    r_y     <= y;
                    r_carry <= cin;
                    r_cnt   <= '0;
                    busy    <= 1'b1;
                    r_state <= RUN;
`ifdef NSA_OVF_EN
                    r_xs    <= x[WIDTH-1];
                    r_ys    <= y[WIDTH-1];
`endif
                end
                RUN: begin
                    r_x     <= r_x >> NIB_W;
                    r_y     <= r_y >> NIB_W;
                    r_acc   <= w_acc;
                    r_carry <= w_co;
                    r_cnt   <= r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        sum     <= w_acc;
                        cout    <= w_co;
                        done    <= 1'b1;
                        r_state <= DONE;
`ifdef NSA_OVF_EN
                        ovf     <= (r_xs == r_ys) && (w_s[NIB_W-1] != r_xs);
`endif
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed vectors with a scoreboard queue checked by a done-driven monitor.
module tb_nibble_serial_adder;
    typedef struct packed {
        logic [15:0] s;
        logic        c;
        logic        o;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] x = '0, y = '0;
    logic        cin = 1'b0;
    logic        busy, done, cout;
    logic [15:0] sum;
    logic        ovf;
    exp_t        q[$];
    exp_t        m_e;
    int          tests = 0;
    int          fails = 0;

`ifndef NSA_OVF_EN
    assign ovf = 1'b0;
`endif

    nibble_serial_adder #(.WIDTH(16)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .x    (x),
        .y    (y),
        .cin  (cin),
        .busy (busy),
        .done (done),
        .sum  (sum),
`ifdef NSA_OVF_EN
        .ovf  (ovf),
`endif
        .cout (cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1 expected no pending result");
            end else begin
                m_e = q.pop_front();
                chk("sum", 32'(sum), 32'(m_e.s));
                chk("cout", 32'(cout), 32'(m_e.c));
`ifdef NSA_OVF_EN
                chk("ovf", 32'(ovf), 32'(m_e.o));
`endif
            end
        end
    end

    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic ci,
                         input logic [15:0] es, input logic ec, input logic eo);
        int n;
        @(negedge clk);
        start = 1'b1; x = a; y = b; cin = ci;
        q.push_back('{s: es, c: ec, o: eo});
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: got no done expected done within 20 cycles");
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_sum", 32'(sum), 0);
        chk("rst_cout", 32'(cout), 0);
        rst = 1'b0;
        // 1: 0+0 with cycle-accurate busy/done profile
        @(negedge clk);
        start = 1'b1; x = 16'h0000; y = 16'h0000; cin = 1'b0;
        q.push_back('{s: 16'h0000, c: 1'b0, o: 1'b0});
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            start = 1'b0;
            chk($sformatf("t1_busy_c%0d", c), 32'(busy), 32'(c <= 5));
            chk($sformatf("t1_done_c%0d", c), 32'(done), 32'(c == 5));
        end
        // 2-4: carry ripple and overflow vectors
        do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        do_op(16'h5A5A, 16'hA5A5, 1'b0, 16'hFFFF, 1'b0, 1'b0);
        do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        do_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        // 5: starts while busy are ignored, including in the DONE cycle
        @(negedge clk);
        start = 1'b1; x = 16'h1234; y = 16'h1111; cin = 1'b0;
        q.push_back('{s: 16'h2345, c: 1'b0, o: 1'b0});
        @(negedge clk);
        x = 16'hFFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_done_c5", 32'(done), 1);
        start = 1'b1; x = 16'hFFFF;
        @(negedge clk);
        start = 1'b0;
        chk("t5_busy_c6", 32'(busy), 0);
        @(negedge clk);
        chk("t5_busy_c7", 32'(busy), 0);
        // 6: reset mid-RUN discards the operation
        @(negedge clk);
        start = 1'b1; x = 16'hFFFF; y = 16'hFFFF; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_busy", 32'(busy), 0);
        chk("t6_done", 32'(done), 0);
        chk("t6_sum", 32'(sum), 0);
        chk("t6_cout", 32'(cout), 0);
        repeat (6) @(negedge clk);
        do_op(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0);
        // rst and start together: start is not accepted
        @(negedge clk);
        rst = 1'b1; start = 1'b1; x = 16'h0001; y = 16'h0001;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("rst_start_busy", 32'(busy), 0);
        repeat (6) @(negedge clk);
        chk("sb_empty", 32'(q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
